alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL match the shared ALU instance.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req_valid[1:0]  input  2  per-requester operation request.
REQ-005 req_ready[1:0]  output  2  per-requester accept; handshake fires on valid&&ready.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands per requester.
REQ-007 req0_sel, req1_sel  input  4 each  ALU op code per requester, forwarded unmodified.
REQ-008 alu_a, alu_b  output  WIDTH  operands to shared ALU.
REQ-009 alu_sel  output  4  op code to shared ALU.
REQ-010 alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_sel).
REQ-011 alu_n, alu_z, alu_v, alu_c  input  1 each  ALU flags.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_id  output  1  index of requester owning the result.
REQ-015 rsp_data  output  WIDTH  registered result.
REQ-016 rsp_flags  output  4  registered {N,Z,V,C}.
REQ-017 busy  output  1  high whenever state != IDLE.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, RESP only.
REQ-019 IDLE: req_ready[i] = grant[i] combinationally; at most one bit of req_ready high; none high outside IDLE.
REQ-020 Grant: only one valid -> that one; both valid -> requester != last_grant; none -> stay IDLE.
REQ-021 On accept: latch a, b, sel, id into op registers; last_grant <= id; IDLE -> EXEC.
REQ-022 alu_a/alu_b/alu_sel SHALL be driven from op registers at all times (no combinational path from req_* to alu_*).
REQ-023 EXEC (one cycle): capture alu_out into rsp_data, {alu_n,alu_z,alu_v,alu_c} into rsp_flags, op id into rsp_id; EXEC -> RESP.
REQ-024 RESP: rsp_valid = 1; rsp_data/rsp_flags/rsp_id SHALL remain stable until rsp_ready sampled high.
REQ-025 RESP with rsp_ready=1 -> IDLE; new request accepted no earlier than the following cycle.
REQ-026 Latency: rsp_valid rises exactly 2 cycles after the accept edge; minimum issue interval 3 cycles.
REQ-027 rsp_valid SHALL be low in IDLE and EXEC.
REQ-028 Op code SHALL not be decoded; undefined codes (0111, 1xxx) pass through to the ALU and the result is returned unchanged.
REQ-029 Requester deasserting req_valid while not granted SHALL have no effect; no request is queued.
REQ-030 A requester SHALL not be starved: with both continuously valid, grants alternate 0,1,0,1.

Reset
REQ-031 rst_n low at a rising edge: state <= IDLE, last_grant <= 1, op registers <= 0, rsp_data <= 0, rsp_flags <= 0, rsp_id <= 0.
REQ-032 Outputs during/after reset: rsp_valid=0, busy=0, req_ready=00 while rst_n low; alu_a=alu_b=0, alu_sel=0000.
REQ-033 Reset in EXEC or RESP SHALL abort the operation; result is discarded and never presented.
REQ-034 First grant after reset with both valid SHALL go to requester 0.

Verification
REQ-035 req0 only, a=0x7FFF b=0x0001 sel=0000 -> accept cycle T, rsp_valid at T+2, rsp_data=0x8000, rsp_flags N=1 Z=0 V=1, rsp_id=0.
REQ-036 both valid continuously after reset, req0 sel=0010 a=0x00F0 b=0x0FF0, req1 sel=0011 a=0x000F b=0x00F0 -> first rsp id=0 data=0x00F0, second id=1 data=0x00FF, third id=0.
REQ-037 req1 a=0x1234 sel=0111, rsp_ready held low 4 cycles in RESP -> rsp_data=0x1234 stable, busy=1, req_ready=00 throughout; IDLE one cycle after rsp_ready=1.
REQ-038 req0 sel=0001 a=0x0005 b=0x0005 -> rsp_data=0x0000, Z=1, N=0.
REQ-039 rst_n low for one edge while in RESP -> next cycle rsp_valid=0, busy=0; subsequent dual request granted to 0.
REQ-040 req_valid pulses on req1 for one cycle while busy -> never granted, no response produced.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Function : Two-requester round-robin front end for one shared combinational ALU.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req0_sel,
    input  logic [3:0]       req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_grant;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [3:0]         r_op_sel;
    logic               r_op_id;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [3:0]         r_rsp_flags;
    logic               r_rsp_id;
    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_grant_id;

    // Grant is gated by rst_n so no handshake can fire on a reset edge.
    always_comb begin
        w_grant = 2'b00;
        if (rst_n && (r_state == ST_IDLE)) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_accept   = |w_grant;
    assign w_grant_id = w_grant[1];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_EXEC;
            ST_EXEC:                w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_sel     <= 4'b0000;
            r_op_id      <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_flags  <= 4'b0000;
            r_rsp_id     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op_a       <= w_grant_id ? req1_a   : req0_a;
                r_op_b       <= w_grant_id ? req1_b   : req0_b;
                r_op_sel     <= w_grant_id ? req1_sel : req0_sel;
                r_op_id      <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data  <= alu_out;
                r_rsp_flags <= {alu_n, alu_z, alu_v, alu_c};
                r_rsp_id    <= r_op_id;
            end
        end
    end

    assign req_ready = w_grant;
    assign alu_a     = r_op_a;
    assign alu_b     = r_op_b;
    assign alu_sel   = r_op_sel;
    assign rsp_valid = rst_n && (r_state == ST_RESP);
    assign busy      = rst_n && (r_state != ST_IDLE);
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign rsp_id    = r_rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Function : Self-checking bench for alu_arbiter with a transaction-level model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_sel, req1_sel;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_sel;
    logic         alu_n, alu_z, alu_v, alu_c;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [W-1:0] rsp_data;
    logic [3:0]   rsp_flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic [3:0]   flags;
    } rsp_t;
    rsp_t rsp_log[$];

    // Reference ALU: returns {N,Z,V,C,result}; unknown codes pass operand a through.
    function automatic logic [W+3:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] sel);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0; v = 1'b0; s = '0;
        case (sel)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = ~s[W];
                        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin r = a << 1; c = a[W-1]; end
            default: r = a;
        endcase
        return {r[W-1], (r == '0), v, c, r};
    endfunction

    assign {alu_n, alu_z, alu_v, alu_c, alu_out} = alu_f(alu_a, alu_b, alu_sel);

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sel(req0_sel), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Fair pick: lone requester wins; on a tie the one not served last wins.
    function automatic logic [1:0] pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    // Model: one transaction in flight, tracked as waiting / computing / presenting.
    int           m_phase = 0;
    logic         m_last  = 1'b1;
    logic [W-1:0] m_a = '0, m_b = '0, m_rdata = '0;
    logic [3:0]   m_sel = '0, m_rflags = '0;
    logic         m_id = 1'b0, m_rid = 1'b0;

    always @(posedge clk) begin
        logic [1:0]   g;
        logic [W+3:0] f;
        if (!rst_n) begin
            m_phase = 0; m_last = 1'b1; m_a = '0; m_b = '0; m_sel = '0; m_id = 1'b0;
            m_rdata = '0; m_rflags = '0; m_rid = 1'b0;
        end else if (m_phase == 0) begin
            g = pick(req_valid, m_last);
            if (g != 2'b00) begin
                m_id    = g[1];
                m_a     = m_id ? req1_a : req0_a;
                m_b     = m_id ? req1_b : req0_b;
                m_sel   = m_id ? req1_sel : req0_sel;
                m_last  = m_id;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            f        = alu_f(m_a, m_b, m_sel);
            m_rdata  = f[W-1:0];
            m_rflags = f[W+3:W];
            m_rid    = m_id;
            m_phase  = 2;
        end else if (rsp_ready) begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready),
            32'((rst_n && m_phase == 0) ? pick(req_valid, m_last) : 2'b00));
        chk("alu_a",     32'(alu_a),     32'(m_a));
        chk("alu_b",     32'(alu_b),     32'(m_b));
        chk("alu_sel",   32'(alu_sel),   32'(m_sel));
        chk("rsp_valid", 32'(rsp_valid), 32'(rst_n && m_phase == 2));
        chk("busy",      32'(busy),      32'(rst_n && m_phase != 0));
        chk("rsp_data",  32'(rsp_data),  32'(m_rdata));
        chk("rsp_flags", 32'(rsp_flags), 32'(m_rflags));
        chk("rsp_id",    32'(rsp_id),    32'(m_rid));
        if (rsp_valid && rsp_ready)
            rsp_log.push_back('{id: rsp_id, data: rsp_data, flags: rsp_flags});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_sel = '0; req1_sel = '0;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_alu_a",     32'(alu_a),     32'h0);
        chk("rst_alu_sel",   32'(alu_sel),   32'h0);
        rst_n = 1'b1; req_valid = 2'b00;
        tick();

        // 0x7FFF + 1: signed overflow into negative
        req_valid = 2'b01; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_sel = 4'b0000;
        chk("t35_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t35_exec_valid", 32'(rsp_valid), 32'h0);
        chk("t35_exec_busy",  32'(busy),      32'h1);
        tick();
        chk("t35_valid", 32'(rsp_valid), 32'h1);
        chk("t35_data",  32'(rsp_data),  32'h8000);
        chk("t35_flags", 32'(rsp_flags), 32'b1010);
        chk("t35_id",    32'(rsp_id),    32'h0);
        tick();
        chk("t35_idle", 32'(busy), 32'h0);

        // Both requesters held valid after a reset: 0,1,0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        rsp_log.delete();
        req0_a = 16'h00F0; req0_b = 16'h0FF0; req0_sel = 4'b0010;
        req1_a = 16'h000F; req1_b = 16'h00F0; req1_sel = 4'b0011;
        req_valid = 2'b11;
        repeat (10) tick();
        req_valid = 2'b00;
        repeat (3) tick();
        chk("t36_count", 32'(rsp_log.size() >= 3), 32'h1);
        if (rsp_log.size() >= 3) begin
            chk("t36_id0",   32'(rsp_log[0].id),   32'h0);
            chk("t36_data0", 32'(rsp_log[0].data), 32'h00F0);
            chk("t36_id1",   32'(rsp_log[1].id),   32'h1);
            chk("t36_data1", 32'(rsp_log[1].data), 32'h00FF);
            chk("t36_id2",   32'(rsp_log[2].id),   32'h0);
        end

        // Undefined op code, consumer stalls for 4 cycles
        rsp_ready = 1'b0;
        req_valid = 2'b10; req1_a = 16'h1234; req1_b = 16'h5678; req1_sel = 4'b0111;
        tick();
        req_valid = 2'b00;
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            chk("t37_data",  32'(rsp_data),  32'h1234);
            chk("t37_busy",  32'(busy),      32'h1);
            chk("t37_ready", 32'(req_ready), 32'h0);
            chk("t37_valid", 32'(rsp_valid), 32'h1);
            tick();
        end
        req_valid = 2'b00; rsp_ready = 1'b1;
        tick();
        chk("t37_idle", 32'(busy), 32'h0);

        // 5 - 5 sets Z, clears N
        req_valid = 2'b01; req0_a = 16'h0005; req0_b = 16'h0005; req0_sel = 4'b0001;
        tick();
        req_valid = 2'b00;
        tick();
        chk("t38_data", 32'(rsp_data),     32'h0);
        chk("t38_z",    32'(rsp_flags[2]), 32'h1);
        chk("t38_n",    32'(rsp_flags[3]), 32'h0);
        tick();

        // Reset while presenting a result
        rsp_ready = 1'b0; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        chk("t39_pre_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t39_valid", 32'(rsp_valid), 32'h0);
        chk("t39_busy",  32'(busy),      32'h0);
        req_valid = 2'b11;
        chk("t39_grant", 32'(req_ready), 32'h1);
        rsp_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        repeat (3) tick();

        // One-cycle pulse from requester 1 while busy is dropped
        rsp_log.delete();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        repeat (5) tick();
        chk("t40_count", 32'(rsp_log.size()), 32'h1);
        if (rsp_log.size() == 1) chk("t40_id", 32'(rsp_log[0].id), 32'h0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req0_a = 16'($urandom); req0_b = 16'($urandom); req0_sel = 4'($urandom);
            req1_a = 16'($urandom); req1_b = 16'($urandom); req1_sel = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 63) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
